// File: rtl/seg_scan_sequencer.sv
// Multiplexed 8-segment scan controller: for each digit, loads its byte into driver74hc164,
// waits for the driver's done edge, lights the digit for a dwell slot, then blanks.
module seg_scan_sequencer #(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] digits,
  output logic [7:0]              drv_data,
  output logic                    drv_shift,
  output logic                    drv_en,
  input  logic                    drv_done,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done,
  output logic                    err
);

  localparam int CNT_MAX_DB = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_DB > TIMEOUT_CYCLES) ? CNT_MAX_DB : TIMEOUT_CYCLES;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW         = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST   = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    WAIT_DONE,
    DWELL,
    BLANK
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [8*NUM_DIGITS-1:0] snapshot;
  logic                    done_q;

  logic                    completion;
  logic                    timeout;
  logic                    blank_exit;
  logic [7:0]              load_byte;
  logic [NUM_DIGITS-1:0]   idx_onehot;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    completion = drv_done & ~done_q;
    timeout    = 1'b0;
    blank_exit = 1'b0;
    load_byte  = (idx == '0) ? digits[7:0] : snapshot[{idx, 3'b000} +: 8];
    idx_onehot = NUM_DIGITS'(1) << idx;
    case (state)
      IDLE:      if (en) next_state = LOAD;
      LOAD:      next_state = SHIFT;
      SHIFT:     next_state = WAIT_DONE;
      WAIT_DONE: begin
        // A done edge in the final wait cycle still counts as completion.
        if (completion) begin
          next_state = DWELL;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          next_state = BLANK;
        end
      end
      DWELL:     if (cnt == DWELL_LAST) next_state = BLANK;
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          blank_exit = 1'b1;
          next_state = en ? LOAD : IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      // NOTE: the frame snapshot is reset too, so a frame never shows stale data after rst.
      snapshot   <= '0;
      done_q     <= 1'b0;
      drv_data   <= 8'h00;
      drv_shift  <= 1'b0;
      drv_en     <= 1'b0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      done_q     <= drv_done;
      cnt        <= (next_state != state || state == IDLE) ? '0 : cnt + 1'b1;
      drv_en     <= (next_state != IDLE);
      drv_shift  <= (next_state == SHIFT);
      dig_sel    <= (next_state == DWELL) ? idx_onehot : '0;
      frame_done <= blank_exit && (idx == IDX_LAST);
      if (timeout) err <= 1'b1;

      // Snapshot at the start of each frame so a mid-frame update cannot tear the display.
      if (state == LOAD) begin
        if (idx == '0) snapshot <= digits;
        drv_data <= load_byte;
      end else if (next_state == IDLE) begin
        drv_data <= 8'h00;
      end

      if (blank_exit) idx <= (idx == IDX_LAST || !en) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_sequencer.sv
// Directed bench for seg_scan_sequencer: behavioural driver74hc164 model plus a dig_sel /
// drv_shift trace monitor; each scenario task compares against hand-computed values.
`timescale 1ns/1ps
module tb_seg_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, drv_done, drv_shift, drv_en, frame_done, err;
  logic [31:0] digits;
  logic [7:0]  drv_data;
  logic [3:0]  dig_sel;

  logic        en3, drv_done3, drv_shift3, drv_en3, frame_done3, err3;
  logic [23:0] digits3;
  logic [7:0]  drv_data3;
  logic [2:0]  dig_sel3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         model_en;
  bit         mute_en;
  logic [7:0] mute_byte;
  int         cd;
  logic       shift3_prev;

  logic [7:0] shifts[$];
  int         shift_cyc[$];
  logic [3:0] lit_val[$];
  int         lit_len[$];
  int         lit_gap[$];
  int         lit_end[$];
  int         fd_count, fd_cyc, err_cyc;
  logic [3:0] cur_sel;
  int         run_len, zero_len;

  seg_scan_sequencer #(
    .NUM_DIGITS(4), .DWELL_CYCLES(10), .BLANK_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits),
    .drv_data(drv_data), .drv_shift(drv_shift), .drv_en(drv_en), .drv_done(drv_done),
    .dig_sel(dig_sel), .frame_done(frame_done), .err(err)
  );

  seg_scan_sequencer #(
    .NUM_DIGITS(3), .DWELL_CYCLES(2), .BLANK_CYCLES(1), .TIMEOUT_CYCLES(4)
  ) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .digits(digits3),
    .drv_data(drv_data3), .drv_shift(drv_shift3), .drv_en(drv_en3), .drv_done(drv_done3),
    .dig_sel(dig_sel3), .frame_done(frame_done3), .err(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Driver model: done is a one-cycle pulse 8 cycles after the shift strobe (suppressed for
  // the muted byte). The 3-digit instance gets its done one cycle after its shift.
  always begin
    @(posedge clk);
    #1;
    if (model_en) begin
      drv_done = 1'b0;
      if (!drv_en) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && !(mute_en && drv_data == mute_byte)) drv_done = 1'b1;
      end
      if (drv_shift) cd = 8;
    end
    if (!drv_en3) begin
      drv_done3   = 1'b0;
      shift3_prev = 1'b0;
    end else begin
      drv_done3   = shift3_prev;
      shift3_prev = drv_shift3;
    end
  end

  // Trace monitor on the falling edge: shift bytes, lit runs of dig_sel, frame_done, err rise.
  always @(negedge clk) begin
    if (drv_shift) begin
      shifts.push_back(drv_data);
      shift_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    if (err && err_cyc < 0) err_cyc = cyc;
    if (dig_sel != cur_sel) begin
      if (cur_sel != 4'b0000) begin
        lit_val.push_back(cur_sel);
        lit_len.push_back(run_len);
        lit_gap.push_back(zero_len);
        lit_end.push_back(cyc - 1);
        zero_len = 0;
      end
      cur_sel = dig_sel;
      run_len = 0;
    end
    if (dig_sel != 4'b0000) run_len++;
    else                    zero_len++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_trace();
    shifts.delete();
    shift_cyc.delete();
    lit_val.delete();
    lit_len.delete();
    lit_gap.delete();
    lit_end.delete();
    fd_count = 0;
    fd_cyc   = -1;
    err_cyc  = -1;
    cur_sel  = dig_sel;
    run_len  = 0;
    zero_len = 0;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    en       = 1'b0;
    en3      = 1'b0;
    drv_done = 1'b0;
    model_en = 1'b1;
    mute_en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tick();
    checks++; if (drv_data !== 8'h00)  begin errors++; $display("FAIL reset_drv_data got %h exp 00", drv_data); end
    checks++; if (drv_shift !== 1'b0)  begin errors++; $display("FAIL reset_drv_shift got %b exp 0", drv_shift); end
    checks++; if (drv_en !== 1'b0)     begin errors++; $display("FAIL reset_drv_en got %b exp 0", drv_en); end
    checks++; if (dig_sel !== 4'b0000) begin errors++; $display("FAIL reset_dig_sel got %b exp 0000", dig_sel); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (drv_en !== 1'b0) begin errors++; $display("FAIL idle_no_en_drv_en got %b exp 0", drv_en); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_b[4];
    int k, t0;
    exp_b  = '{8'h3F, 8'h4A, 8'hAD, 8'hDE};
    digits = 32'hDEAD_4A3F;
    clear_trace();
    en = 1'b1;
    t0 = cyc;
    k  = 0;
    while (fd_count == 0 && k < 200) begin tick(); k++; end
    checks++; if (fd_count == 0) begin errors++; $display("FAIL basic_frame_wait got no frame_done exp one within 200 cycles"); end
    checks++; if (shift_cyc[0] - t0 != 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", shift_cyc[0] - t0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (shifts[i] !== exp_b[i]) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, shifts[i], exp_b[i]); end
      checks++; if (lit_val[i] !== 4'(1 << i)) begin errors++; $display("FAIL basic_dig_sel[%0d] got %b exp %b", i, lit_val[i], 4'(1 << i)); end
      checks++; if (lit_len[i] != 10) begin errors++; $display("FAIL basic_dwell_len[%0d] got %0d exp 10", i, lit_len[i]); end
    end
    // Dark time between slots: 2 blank + 1 load + 1 shift + 8 waiting for done.
    for (int i = 1; i < 4; i++) begin
      checks++; if (lit_gap[i] != 12) begin errors++; $display("FAIL basic_gap[%0d] got %0d exp 12", i, lit_gap[i]); end
    end
    checks++; if (shift_cyc[1] - shift_cyc[0] != 22) begin errors++; $display("FAIL basic_slot_period got %0d exp 22", shift_cyc[1] - shift_cyc[0]); end
    checks++; if (fd_count != 1) begin errors++; $display("FAIL basic_fd_count got %0d exp 1", fd_count); end
    checks++; if (fd_cyc != lit_end[3] + 3) begin errors++; $display("FAIL basic_fd_time got %0d exp %0d", fd_cyc, lit_end[3] + 3); end
  endtask

  task automatic test_snapshot();
    int k;
    clear_trace();
    k = 0;
    while (shifts.size() < 3 && k < 100) begin tick(); k++; end
    digits = 32'hFFFF_FFFF;
    k = 0;
    while (shifts.size() < 8 && k < 200) begin tick(); k++; end
    checks++; if (shifts.size() < 8) begin errors++; $display("FAIL snap_wait got %0d shifts exp 8", shifts.size()); end
    checks++; if (shifts[2] !== 8'hAD) begin errors++; $display("FAIL snap_digit2 got %h exp AD", shifts[2]); end
    checks++; if (shifts[3] !== 8'hDE) begin errors++; $display("FAIL snap_digit3 got %h exp DE", shifts[3]); end
    for (int i = 4; i < 8; i++) begin
      checks++; if (shifts[i] !== 8'hFF) begin errors++; $display("FAIL snap_next_frame[%0d] got %h exp FF", i, shifts[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_l[4];
    bit seen2;
    int k;
    exp_l = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    digits    = 32'hDEAD_4A3F;
    mute_en   = 1'b1;
    mute_byte = 8'h4A;
    clear_trace();
    en = 1'b1;
    k  = 0;
    while (shifts.size() < 7 && k < 400) begin tick(); k++; end
    checks++; if (shifts.size() < 7) begin errors++; $display("FAIL to_wait got %0d shifts exp 7", shifts.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b exp 1", err); end
    checks++; if (err_cyc - shift_cyc[1] != 65) begin errors++; $display("FAIL to_err_time got %0d exp 65", err_cyc - shift_cyc[1]); end
    checks++; if (shift_cyc[2] - shift_cyc[1] != 68) begin errors++; $display("FAIL to_next_shift got %0d exp 68", shift_cyc[2] - shift_cyc[1]); end
    checks++; if (shifts[2] !== 8'hAD) begin errors++; $display("FAIL to_digit2_data got %h exp AD", shifts[2]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (lit_val[i] !== exp_l[i]) begin errors++; $display("FAIL to_lit[%0d] got %b exp %b", i, lit_val[i], exp_l[i]); end
    end
    checks++; if (lit_len[1] != 10) begin errors++; $display("FAIL to_digit2_dwell got %0d exp 10", lit_len[1]); end
    seen2 = 1'b0;
    foreach (lit_val[i]) if (lit_val[i] == 4'b0010) seen2 = 1'b1;
    checks++; if (seen2) begin errors++; $display("FAIL to_digit1_lit got lit exp never lit"); end
    checks++; if (fd_count != 1) begin errors++; $display("FAIL to_fd_count got %0d exp 1", fd_count); end
    en = 1'b0;
  endtask

  task automatic test_stale_done();
    int k, s;
    apply_reset();
    model_en = 1'b0;
    drv_done = 1'b1;
    tick();
    clear_trace();
    en = 1'b1;
    k  = 0;
    while (!drv_shift && k < 10) begin tick(); k++; end
    s = cyc;
    k = 0;
    while (!err && k < 80) begin tick(); k++; end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err got %b exp 1", err); end
    checks++; if (cyc - s != 65) begin errors++; $display("FAIL stale_err_time got %0d exp 65", cyc - s); end
    tick();
    tick();
    checks++; if (lit_val.size() != 0 || dig_sel !== 4'b0000) begin errors++; $display("FAIL stale_no_dwell got %0d lit runs exp 0", lit_val.size()); end

    apply_reset();
    model_en = 1'b0;
    drv_done = 1'b1;
    clear_trace();
    en = 1'b1;
    k  = 0;
    while (!drv_shift && k < 10) begin tick(); k++; end
    tick();
    tick();
    tick();
    drv_done = 1'b0;
    tick();
    drv_done = 1'b1;
    tick();
    checks++; if (dig_sel !== 4'b0001) begin errors++; $display("FAIL stale_repulse_dwell got %b exp 0001", dig_sel); end
    k = 0;
    while (lit_val.size() < 1 && k < 20) begin tick(); k++; end
    checks++; if (lit_len[0] != 10) begin errors++; $display("FAIL stale_repulse_len got %0d exp 10", lit_len[0]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stale_repulse_err got %b exp 0", err); end
  endtask

  task automatic test_simultaneous();
    int k;
    apply_reset();
    model_en = 1'b0;
    drv_done = 1'b0;
    en = 1'b1;
    k  = 0;
    while (!drv_shift && k < 10) begin tick(); k++; end
    repeat (64) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_early_timeout got %b exp 0", err); end
    drv_done = 1'b1;
    tick();
    checks++; if (dig_sel !== 4'b0001) begin errors++; $display("FAIL sim_completion_wins got %b exp 0001", dig_sel); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_err got %b exp 0", err); end
  endtask

  task automatic test_en_drop();
    int k;
    apply_reset();
    digits = 32'hDEAD_4A3F;
    clear_trace();
    en = 1'b1;
    k  = 0;
    while (dig_sel !== 4'b0010 && k < 100) begin tick(); k++; end
    en = 1'b0;
    k  = 0;
    while (drv_en && k < 40) begin tick(); k++; end
    checks++; if (drv_en !== 1'b0) begin errors++; $display("FAIL endrop_idle got %b exp 0", drv_en); end
    checks++; if (cyc - lit_end[1] != 3) begin errors++; $display("FAIL endrop_idle_time got %0d exp 3", cyc - lit_end[1]); end
    checks++; if (lit_len[1] != 10) begin errors++; $display("FAIL endrop_dwell got %0d exp 10", lit_len[1]); end
    checks++; if (fd_count != 0) begin errors++; $display("FAIL endrop_fd got %0d exp 0", fd_count); end
    checks++; if (shifts.size() != 2) begin errors++; $display("FAIL endrop_shifts got %0d exp 2", shifts.size()); end
    checks++; if (drv_data !== 8'h00) begin errors++; $display("FAIL endrop_idle_data got %h exp 00", drv_data); end
    tick();
    tick();
    en = 1'b1;
    tick();
    tick();
    checks++; if (drv_shift !== 1'b1 || drv_data !== 8'h3F) begin errors++; $display("FAIL endrop_restart got shift %b data %h exp 1 3F", drv_shift, drv_data); end
  endtask

  task automatic test_reset_mid_shift();
    int k;
    apply_reset();
    digits = 32'hDEAD_4A3F;
    en = 1'b1;
    k  = 0;
    while (!drv_shift && k < 10) begin tick(); k++; end
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (drv_data !== 8'h00)  begin errors++; $display("FAIL midrst_drv_data got %h exp 00", drv_data); end
    checks++; if (drv_en !== 1'b0 || drv_shift !== 1'b0) begin errors++; $display("FAIL midrst_drv_ctrl got en %b shift %b exp 0 0", drv_en, drv_shift); end
    checks++; if (dig_sel !== 4'b0000 || frame_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_outs got sel %b fd %b err %b exp 0", dig_sel, frame_done, err); end
    rst = 1'b0;
    tick();
    checks++; if (drv_shift !== 1'b0 || drv_en !== 1'b1) begin errors++; $display("FAIL midrst_load got shift %b en %b exp 0 1", drv_shift, drv_en); end
    tick();
    checks++; if (drv_shift !== 1'b1 || drv_data !== 8'h3F) begin errors++; $display("FAIL midrst_shift got shift %b data %h exp 1 3F", drv_shift, drv_data); end
  endtask

  task automatic test_non_pow2();
    logic [7:0] exp_b[4];
    logic [2:0] exp_s[4];
    logic [7:0] bytes[$];
    logic [2:0] sels[$];
    logic [2:0] prev_sel;
    int t0, fd_first;
    exp_b    = '{8'h11, 8'h22, 8'h33, 8'h11};
    exp_s    = '{3'b001, 3'b010, 3'b100, 3'b001};
    prev_sel = 3'b000;
    fd_first = -1;
    en       = 1'b0;
    digits3  = 24'h33_22_11;
    en3      = 1'b1;
    t0       = cyc;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (drv_shift3) bytes.push_back(drv_data3);
      if (dig_sel3 != 3'b000 && prev_sel == 3'b000) sels.push_back(dig_sel3);
      prev_sel = dig_sel3;
      if (frame_done3 && fd_first < 0) fd_first = cyc - t0;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL np2_data[%0d] got %h exp %h", i, bytes[i], exp_b[i]); end
      checks++; if (sels[i] !== exp_s[i]) begin errors++; $display("FAIL np2_sel[%0d] got %b exp %b", i, sels[i], exp_s[i]); end
    end
    checks++; if (fd_first != 19) begin errors++; $display("FAIL np2_fd_time got %0d exp 19", fd_first); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL np2_err got %b exp 0", err3); end
    en3 = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    en3         = 1'b0;
    digits      = 32'h0;
    digits3     = 24'h0;
    drv_done    = 1'b0;
    drv_done3   = 1'b0;
    shift3_prev = 1'b0;
    model_en    = 1'b1;
    mute_en     = 1'b0;
    mute_byte   = 8'h00;
    cd          = 0;
    cur_sel     = 4'b0000;
    err_cyc     = -1;
    fd_cyc      = -1;
    fd_count    = 0;
    run_len     = 0;
    zero_len    = 0;

    test_reset();
    test_basic_frame();
    test_snapshot();
    test_timeout();
    test_stale_done();
    test_simultaneous();
    test_en_drop();
    test_reset_mid_shift();
    test_non_pow2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
